// File: rtl/store_rmw_unit_pkg.sv
// Shared store-path definitions: access-size encodings and alignment rule.
// Size encodings match the load-extend select so both paths decode st_size/ld_size identically.
// Pure declarations; no logic state.
package store_rmw_unit_pkg;

  localparam logic [1:0] SIZE_W = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_B = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // A request is rejected when its size is illegal or its address is not naturally aligned.
  function automatic logic size_addr_illegal(input logic [1:0] size, input logic [1:0] byte_off);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_X) begin
      bad = 1'b1;
    end else if (size == SIZE_H) begin
      bad = byte_off[0];
    end else if (size == SIZE_W) begin
      bad = (byte_off != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Bundle of the store request handshake and the word-wide single-port memory port.
// master = core + memory side, slave = the store unit itself.
// No timing of its own; signals are registered or decoded inside the unit.
interface store_rmw_unit_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              st_done;
  logic              st_misaligned;
  logic              busy;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_rdata,
    input  st_ready, st_done, st_misaligned, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_rdata,
    output st_ready, st_done, st_misaligned, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/store_lane_merge.sv
// Replaces the byte or half-word lane(s) selected by byte_off in old_word with new_data.
// Latency: combinational.
// Backpressure: none.
module store_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] new_data,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  // Little-endian lanes: lane 0 is bits [7:0]; half-word pair chosen by byte_off[1].
  always_comb begin
    merged = old_word;
    if (size == SIZE_B) begin
      merged[{byte_off, 3'b000} +: 8] = new_data[7:0];
    end else if (size == SIZE_H) begin
      merged[{byte_off[1], 4'b0000} +: 16] = new_data;
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// SW/SH/SB store into a word-only single-port memory; sub-word stores read-modify-write.
// Latency from accept: word store or reject done +1 cycle, sub-word done +3 cycles.
// Backpressure: st_ready only in IDLE; st_valid while busy is ignored.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  store_rmw_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [MEM_AW+1:0] addr_q, addr_d;     // bits above the word index are never needed
  logic [15:0]       data_lo_q, data_lo_d; // sub-word stores only use the low half
  logic [1:0]        size_q, size_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       merged_w;

  store_lane_merge u_merge (
    .old_word (bus.mem_rdata),
    .new_data (data_lo_q),
    .byte_off (addr_q[1:0]),
    .size     (size_q),
    .merged   (merged_w)
  );

  // State and captured request registers; reset abandons any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_lo_q <= '0;
      size_q    <= '0;
      merged_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_lo_q <= data_lo_d;
      size_q    <= size_d;
      merged_q  <= merged_d;
    end
  end

  // Next state and capture: word stores preload merged_q with the full word so WRITE needs no mux.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_lo_d = data_lo_q;
    size_d    = size_q;
    merged_d  = merged_q;
    case (state_q)
      S_IDLE: begin
        if (bus.st_valid) begin
          addr_d    = bus.st_addr[MEM_AW+1:0];
          data_lo_d = bus.st_data[15:0];
          size_d    = bus.st_size;
          merged_d  = bus.st_data;
          if (size_addr_illegal(bus.st_size, bus.st_addr[1:0])) begin
            state_d = S_ERR;
          end else if (bus.st_size == SIZE_W) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: begin
        merged_d = merged_w;
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; memory address and data are forced to zero outside the strobe states.
  always_comb begin
    bus.st_ready      = (state_q == S_IDLE);
    bus.busy          = (state_q != S_IDLE);
    bus.st_done       = 1'b0;
    bus.st_misaligned = 1'b0;
    bus.mem_rd_en     = 1'b0;
    bus.mem_wr_en     = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    case (state_q)
      S_READ: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_q[MEM_AW+1:2];
      end
      S_WRITE: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = addr_q[MEM_AW+1:2];
        bus.mem_wdata = merged_q;
        bus.st_done   = 1'b1;
      end
      S_ERR: begin
        bus.st_done       = 1'b1;
        bus.st_misaligned = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
